sha256_arbiter: RTL and testbench

SHA256_ARBITER -- requirements
Module: sha256_arbiter

---
 rtl/sha256_pkg.sv | 13 +
 rtl/sha256_arbiter.sv | 154 +++++++++++++++
 tb/tb_sha256_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types for the SHA-256 transform and the requester arbiter.
package sha256_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned STATE_WD = 8;
   localparam int unsigned LEN_W    = 64;

   typedef struct packed {
      logic [STATE_WD-1:0][WORD_W-1:0] h;
      logic [LEN_W-1:0]                len;
   } ShaContext;

endpackage

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one sha256_transform between NUM_REQ requesters.
// One job in flight: grant, issue ctx+chunk, wait for hash, return it to the owner.
module sha256_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_REQ-1:0]                     req_vld,
   output logic [NUM_REQ-1:0]                     req_rdy,
   input  sha256_pkg::ShaContext [NUM_REQ-1:0]    req_ctx,
   input  logic [NUM_REQ-1:0][15:0][31:0]         req_chunk,
   output logic [NUM_REQ-1:0]                     rsp_vld,
   input  logic [NUM_REQ-1:0]                     rsp_rdy,
   output logic [255:0]                           rsp_hash,
   output logic                                   core_ctx_vld,
   input  logic                                   core_ctx_rdy,
   output sha256_pkg::ShaContext                  core_ctx,
   output logic                                   core_chunk_vld,
   input  logic                                   core_chunk_rdy,
   output logic [15:0][31:0]                      core_chunk,
   input  logic                                   core_hash_vld,
   output logic                                   core_hash_rdy,
   input  logic [255:0]                           core_hash,
   output logic                                   busy,
   output logic [$clog2(NUM_REQ)-1:0]             owner,
   output logic [CNT_W-1:0]                       jobs_done
);

   localparam int unsigned OWN_W  = $clog2(NUM_REQ);
   localparam int unsigned HASH_W = 256;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_e;

   state_e                state_q, state_d;
   logic [OWN_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [OWN_W-1:0]      owner_q, owner_d;
   logic [CNT_W-1:0]      jobs_done_q, jobs_done_d;
   logic                  ctx_sent_q, ctx_sent_d;
   logic                  chunk_sent_q, chunk_sent_d;
   sha256_pkg::ShaContext ctx_q, ctx_d;
   logic [15:0][31:0]     chunk_q, chunk_d;
   logic [HASH_W-1:0]     hash_q, hash_d;

   logic [2*NUM_REQ-1:0]  vld_dbl;
   logic [NUM_REQ-1:0]    vld_rot;
   logic                  gnt_found;
   logic [OWN_W-1:0]      gnt_idx;

   // Rotate requests so bit 0 is rr_ptr, then take the first set bit.
   always_comb begin
      vld_dbl   = {req_vld, req_vld} >> rr_ptr_q;
      vld_rot   = vld_dbl[NUM_REQ-1:0];
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!gnt_found && vld_rot[k]) begin
            gnt_found = 1'b1;
            gnt_idx   = OWN_W'((32'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      req_rdy = '0;
      if (state_q == IDLE && gnt_found && !rst) begin
         req_rdy = NUM_REQ'(1) << gnt_idx;
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      jobs_done_d  = jobs_done_q;
      ctx_sent_d   = ctx_sent_q;
      chunk_sent_d = chunk_sent_q;
      ctx_d        = ctx_q;
      chunk_d      = chunk_q;
      hash_d       = hash_q;
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               ctx_d        = req_ctx[gnt_idx];
               chunk_d      = req_chunk[gnt_idx];
               owner_d      = gnt_idx;
               ctx_sent_d   = 1'b0;
               chunk_sent_d = 1'b0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            // Each valid is high only while unsent, so rdy alone completes its handshake.
            ctx_sent_d   = ctx_sent_q | core_ctx_rdy;
            chunk_sent_d = chunk_sent_q | core_chunk_rdy;
            if (ctx_sent_d && chunk_sent_d) begin
               ctx_sent_d   = 1'b0;
               chunk_sent_d = 1'b0;
               state_d      = WAIT;
            end
         end
         WAIT: begin
            if (core_hash_vld) begin
               hash_d  = core_hash;
               state_d = RETURN;
            end
         end
         RETURN: begin
            if (rsp_rdy[owner_q]) begin
               rr_ptr_d    = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
               jobs_done_d = jobs_done_q + CNT_W'(1);
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         jobs_done_q  <= '0;
         ctx_sent_q   <= 1'b0;
         chunk_sent_q <= 1'b0;
         ctx_q        <= '0;
         chunk_q      <= '0;
         hash_q       <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         jobs_done_q  <= jobs_done_d;
         ctx_sent_q   <= ctx_sent_d;
         chunk_sent_q <= chunk_sent_d;
         ctx_q        <= ctx_d;
         chunk_q      <= chunk_d;
         hash_q       <= hash_d;
      end
   end

   assign rsp_vld        = (state_q == RETURN) ? (NUM_REQ'(1) << owner_q) : '0;
   assign rsp_hash       = hash_q;
   assign core_ctx_vld   = (state_q == ISSUE) && !ctx_sent_q;
   assign core_chunk_vld = (state_q == ISSUE) && !chunk_sent_q;
   assign core_ctx       = ctx_q;
   assign core_chunk     = chunk_q;
   assign core_hash_rdy  = (state_q == WAIT);
   assign busy           = (state_q != IDLE);
   assign owner          = owner_q;
   assign jobs_done      = jobs_done_q;

endmodule

// File: tb/tb_sha256_arbiter.sv
// Bench for sha256_arbiter: transaction-level model checked every cycle plus directed scenarios.
module tb_sha256_arbiter;
   import sha256_pkg::*;

   localparam int N = 4;
   localparam int W = 512;
   localparam logic [255:0] H_A5  = {32{8'hA5}};
   localparam logic [255:0] H_BAD = {8{32'hDEAD_BEEF}};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [N-1:0]            req_vld, rsp_rdy;
   logic [N-1:0]            req_rdy, req_rdy_w, rsp_vld, rsp_vld_w;
   ShaContext [N-1:0]       req_ctx;
   logic [N-1:0][15:0][31:0] req_chunk;
   logic [255:0]            rsp_hash, rsp_hash_w, core_hash;
   logic                    core_ctx_rdy, core_chunk_rdy, core_hash_vld;
   logic                    core_ctx_vld, core_ctx_vld_w, core_chunk_vld, core_chunk_vld_w;
   ShaContext               core_ctx, core_ctx_w;
   logic [15:0][31:0]       core_chunk, core_chunk_w;
   logic                    core_hash_rdy, core_hash_rdy_w, busy, busy_w;
   logic [1:0]              owner, owner_w, jobs_done_w;
   logic [15:0]             jobs_done;

   sha256_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_ctx(req_ctx),
      .req_chunk(req_chunk), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_hash(rsp_hash),
      .core_ctx_vld(core_ctx_vld), .core_ctx_rdy(core_ctx_rdy), .core_ctx(core_ctx),
      .core_chunk_vld(core_chunk_vld), .core_chunk_rdy(core_chunk_rdy), .core_chunk(core_chunk),
      .core_hash_vld(core_hash_vld), .core_hash_rdy(core_hash_rdy), .core_hash(core_hash),
      .busy(busy), .owner(owner), .jobs_done(jobs_done));

   sha256_arbiter #(.NUM_REQ(4), .CNT_W(2)) dut_w (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy_w), .req_ctx(req_ctx),
      .req_chunk(req_chunk), .rsp_vld(rsp_vld_w), .rsp_rdy(rsp_rdy), .rsp_hash(rsp_hash_w),
      .core_ctx_vld(core_ctx_vld_w), .core_ctx_rdy(core_ctx_rdy), .core_ctx(core_ctx_w),
      .core_chunk_vld(core_chunk_vld_w), .core_chunk_rdy(core_chunk_rdy), .core_chunk(core_chunk_w),
      .core_hash_vld(core_hash_vld), .core_hash_rdy(core_hash_rdy_w), .core_hash(core_hash),
      .busy(busy_w), .owner(owner_w), .jobs_done(jobs_done_w));

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk2(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp);
      chk(name, a, exp);
      chk({name, "_w"}, b, exp);
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // Model: one job at a time, tracked as grant -> ctx/chunk accepted -> hash got -> returned.
   logic              m_active, m_ctx_done, m_chunk_done, m_hash_got;
   logic [1:0]        m_owner;
   int                m_ptr;
   logic [31:0]       m_done;
   logic [255:0]      m_hash;
   ShaContext         m_ctx;
   logic [15:0][31:0] m_chunk;
   int                c_g;
   logic [N-1:0]      c_rdy, c_rsp;
   logic              c_hrdy;

   always @(negedge clk or posedge rst) begin
      if (rst) begin
         #1;
         chk2("rst_req_rdy", W'(req_rdy), W'(req_rdy_w), W'(0));
         chk2("rst_rsp_vld", W'(rsp_vld), W'(rsp_vld_w), W'(0));
         chk2("rst_ctx_vld", W'(core_ctx_vld), W'(core_ctx_vld_w), W'(0));
         chk2("rst_chunk_vld", W'(core_chunk_vld), W'(core_chunk_vld_w), W'(0));
         chk2("rst_hash_rdy", W'(core_hash_rdy), W'(core_hash_rdy_w), W'(0));
         chk2("rst_busy", W'(busy), W'(busy_w), W'(0));
         chk2("rst_rsp_hash", W'(rsp_hash), W'(rsp_hash_w), W'(0));
         chk2("rst_owner", W'(owner), W'(owner_w), W'(0));
         chk("rst_jobs_done", W'(jobs_done), W'(0));
         chk("rst_jobs_done_w", W'(jobs_done_w), W'(0));
         m_active = 1'b0; m_ctx_done = 1'b0; m_chunk_done = 1'b0; m_hash_got = 1'b0;
         m_owner = 2'd0; m_ptr = 0; m_done = 32'd0; m_hash = '0;
      end else begin
         c_g    = rr_pick(req_vld, m_ptr);
         c_rdy  = (!m_active && c_g >= 0) ? (4'b0001 << c_g) : 4'b0000;
         c_hrdy = m_active && m_ctx_done && m_chunk_done && !m_hash_got;
         c_rsp  = (m_active && m_hash_got) ? (4'b0001 << m_owner) : 4'b0000;
         chk2("req_rdy", W'(req_rdy), W'(req_rdy_w), W'(c_rdy));
         chk2("busy", W'(busy), W'(busy_w), W'(m_active));
         chk2("core_ctx_vld", W'(core_ctx_vld), W'(core_ctx_vld_w), W'(m_active && !m_ctx_done));
         chk2("core_chunk_vld", W'(core_chunk_vld), W'(core_chunk_vld_w),
              W'(m_active && !m_chunk_done));
         chk2("core_hash_rdy", W'(core_hash_rdy), W'(core_hash_rdy_w), W'(c_hrdy));
         chk2("rsp_vld", W'(rsp_vld), W'(rsp_vld_w), W'(c_rsp));
         chk2("rsp_hash", W'(rsp_hash), W'(rsp_hash_w), W'(m_hash));
         chk2("owner", W'(owner), W'(owner_w), W'(m_owner));
         chk("jobs_done", W'(jobs_done), W'(m_done[15:0]));
         chk("jobs_done_w", W'(jobs_done_w), W'(m_done[1:0]));
         if (m_active && !m_ctx_done) chk2("core_ctx", W'(core_ctx), W'(core_ctx_w), W'(m_ctx));
         if (m_active && !m_chunk_done)
            chk2("core_chunk", W'(core_chunk), W'(core_chunk_w), W'(m_chunk));
         if (!m_active) begin
            if (c_g >= 0) begin
               m_active = 1'b1; m_ctx_done = 1'b0; m_chunk_done = 1'b0; m_hash_got = 1'b0;
               m_owner  = 2'(c_g);
               m_ctx    = req_ctx[c_g];
               m_chunk  = req_chunk[c_g];
            end
         end else begin
            if (!m_ctx_done && core_ctx_rdy) m_ctx_done = 1'b1;
            if (!m_chunk_done && core_chunk_rdy) m_chunk_done = 1'b1;
            if (c_hrdy && core_hash_vld) begin
               m_hash_got = 1'b1;
               m_hash     = core_hash;
            end else if (m_hash_got && rsp_rdy[m_owner]) begin
               m_active = 1'b0;
               m_ptr    = (int'(m_owner) + 1) % N;
               m_done   = m_done + 32'd1;
            end
         end
      end
   end

   // One full job; entered and left at posedge+1. lat = edges from grant to hash_rdy seen.
   task automatic do_job(input logic [N-1:0] mask, input logic [255:0] h, input int chunk_dly,
                         input int rsp_dly, output int g, output logic [N-1:0] rv,
                         output logic [255:0] rh, output int lat);
      int n;
      int c0;
      g = -1; rv = '0; rh = '0; lat = -1;
      req_vld        = mask;
      core_chunk_rdy = (chunk_dly == 0);
      n = 0;
      @(negedge clk);
      while (req_rdy == '0 && n < 50) begin @(negedge clk); n++; end
      if (req_rdy == '0) begin timeout_fail("grant"); return; end
      for (int i = 0; i < N; i++) if (req_rdy[i]) g = i;
      c0 = cyc;
      @(posedge clk); #1;
      req_ctx[g]   = ~req_ctx[g];
      req_chunk[g] = ~req_chunk[g];
      if (chunk_dly > 0) begin
         repeat (chunk_dly) begin @(posedge clk); #1; end
         core_chunk_rdy = 1'b1;
      end
      n = 0;
      @(negedge clk);
      while (!core_hash_rdy && n < 50) begin @(negedge clk); n++; end
      if (!core_hash_rdy) begin timeout_fail("hash_rdy"); return; end
      lat = cyc - c0;
      @(posedge clk); #1;
      core_hash_vld = 1'b1;
      core_hash     = h;
      @(posedge clk); #1;
      core_hash_vld = 1'b0;
      n = 0;
      @(negedge clk);
      while (rsp_vld == '0 && n < 50) begin @(negedge clk); n++; end
      if (rsp_vld == '0) begin timeout_fail("rsp_vld"); return; end
      rv = rsp_vld;
      rh = rsp_hash;
      @(posedge clk); #1;
      for (int k = 0; k < rsp_dly; k++) begin
         rsp_rdy       = ~(4'b0001 << g);
         core_hash_vld = 1'b1;
         core_hash     = H_BAD;
         @(posedge clk); #1;
      end
      core_hash_vld = 1'b0;
      rsp_rdy       = 4'b0001 << g;
      @(posedge clk); #1;
      rsp_rdy = '0;
      req_vld = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst     = 1'b1;
      req_vld = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   int           g, lat, n;
   logic [N-1:0] rv;
   logic [255:0] rh;
   logic [1:0]   wrap_exp [0:4];

   initial begin
      wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      rst = 1'b1;
      req_vld = 4'b1111;
      rsp_rdy = '0;
      core_ctx_rdy = 1'b1; core_chunk_rdy = 1'b1; core_hash_vld = 1'b0; core_hash = '0;
      for (int i = 0; i < N; i++) begin
         req_ctx[i]   = ShaContext'({10{32'(i * 17 + 3)}});
         req_chunk[i] = {16{32'hC000_0000 | 32'(i)}};
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      req_vld = '0;
      @(posedge clk); #1;

      // Single job from requester 2
      do_job(4'b0100, H_A5, 0, 0, g, rv, rh, lat);
      chk("single_grant", W'(g), W'(2));
      chk("single_rsp_vld", W'(rv), W'(4'b0100));
      chk("single_rsp_hash", W'(rh), W'(H_A5));
      chk("single_latency", W'(lat), W'(2));
      chk("single_jobs_done", W'(jobs_done), W'(1));

      // Fairness from a fresh reset, plus 2-bit counter wrap
      do_reset();
      for (int k = 0; k < 8; k++) begin
         do_job(4'b1111, {8{32'h1000 + 32'(k)}}, 0, 0, g, rv, rh, lat);
         chk("fair_grant", W'(g), W'(k % 4));
         if (k < 5) chk("wrap_jobs_done_w", W'(jobs_done_w), W'(wrap_exp[k]));
      end
      chk("fair_jobs_done", W'(jobs_done), W'(8));

      // Chunk accepted 3 cycles after ctx
      do_job(4'b0001, {8{32'h5151_0000}}, 3, 0, g, rv, rh, lat);
      chk("split_grant", W'(g), W'(0));
      chk("split_latency", W'(lat), W'(5));

      // Response backpressure with non-owner rsp_rdy and stray core_hash_vld
      do_job(4'b0110, {8{32'h7777_2222}}, 0, 5, g, rv, rh, lat);
      chk("bp_grant", W'(g), W'(1));
      chk("bp_rsp_vld", W'(rv), W'(4'b0010));
      chk("bp_rsp_hash", W'(rsp_hash), W'({8{32'h7777_2222}}));
      chk("bp_jobs_done", W'(jobs_done), W'(10));

      // Asynchronous reset while waiting for the hash
      req_vld = 4'b0010;
      n = 0;
      @(negedge clk);
      while (req_rdy == '0 && n < 50) begin @(negedge clk); n++; end
      if (req_rdy == '0) timeout_fail("rst_grant");
      @(posedge clk); #1;
      req_vld = '0;
      n = 0;
      @(negedge clk);
      while (!core_hash_rdy && n < 50) begin @(negedge clk); n++; end
      if (!core_hash_rdy) timeout_fail("rst_hash_rdy");
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midrst_busy", W'(busy), W'(0));
      chk("midrst_hash_rdy", W'(core_hash_rdy), W'(0));
      chk("midrst_jobs_done", W'(jobs_done), W'(0));
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_job(4'b1010, {8{32'h0BAD_F00D}}, 0, 0, g, rv, rh, lat);
      chk("postrst_grant", W'(g), W'(1));
      chk("postrst_jobs_done", W'(jobs_done), W'(1));

      // Search wraps from rr_ptr=2 past the top back to 0
      do_job(4'b0011, {8{32'h3030_3030}}, 0, 0, g, rv, rh, lat);
      chk("wrap_grant", W'(g), W'(0));

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
